// File: rtl/titan_if_stage_pkg.sv
// Shared definitions for the titan instruction-fetch stage.
//   - RESET_ADDR_DEFAULT : default PC after reset
//   - NOP_INST_DEFAULT   : bubble instruction (addi x0,x0,0)
//   - if_state_e         : fetch sequencer states
package titan_if_stage_pkg;

    localparam logic [31:0] RESET_ADDR_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] NOP_INST_DEFAULT   = 32'h0000_0013;

    typedef enum logic [1:0] {
        StFetch = 2'd0,  // request in flight or about to launch
        StKill  = 2'd1,  // waiting out a wrong-path request
        StHold  = 2'd2   // response parked while decode is stalled
    } if_state_e;

endpackage

// File: rtl/titan_ifid_register.sv
// IF/ID pipeline register.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-low reset
//   flush_i             load a bubble (highest priority)
//   stall_i             hold current contents
//   valid_i             load pc/inst/flags, otherwise load a bubble
//   pc_i, inst_i, misaligned_i, fault_i   incoming fetch result
//   id_*_o              registered values presented to decode
module titan_ifid_register
    import titan_if_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        stall_i,
    input  logic        valid_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] inst_i,
    input  logic        misaligned_i,
    input  logic        fault_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_instruction_o,
    output logic        id_inst_addr_misaligned_o,
    output logic        id_inst_access_fault_o
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        mis_q, mis_d;
    logic        fault_q, fault_d;

    always_comb begin
        pc_d    = pc_q;
        inst_d  = inst_q;
        mis_d   = mis_q;
        fault_d = fault_q;
        if (flush_i || (!stall_i && !valid_i)) begin
            pc_d    = 32'h0;
            inst_d  = NOP_INST;
            mis_d   = 1'b0;
            fault_d = 1'b0;
        end else if (!stall_i) begin
            pc_d    = pc_i;
            inst_d  = inst_i;
            mis_d   = misaligned_i;
            fault_d = fault_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_q    <= 32'h0;
            inst_q  <= NOP_INST;
            mis_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            mis_q   <= mis_d;
            fault_q <= fault_d;
        end
    end

    assign id_pc_o                   = pc_q;
    assign id_instruction_o          = inst_q;
    assign id_inst_addr_misaligned_o = mis_q;
    assign id_inst_access_fault_o    = fault_q;

endmodule

// File: rtl/titan_if_stage.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding fetches,
// applies trap/branch/jump redirects and feeds decode through the IF/ID register.
// Ports:
//   clk_i, rst_i                          clock, asynchronous active-low reset
//   if_stall_i, if_flush_i                decode stall / bubble request
//   take_branch_i, pc_branch_address_i    taken branch from decode
//   take_jump_i, pc_jump_address_i        jal/jalr from decode
//   trap_valid_i, trap_address_i          trap / xret redirect
//   iport_*                               instruction bus (cyc/stb/addr, ack/err/data)
//   id_*_o                                IF/ID register outputs
//   if_busy_o                             bus request outstanding
module titan_if_stage
    import titan_if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = RESET_ADDR_DEFAULT,
    parameter logic [31:0] NOP_INST   = NOP_INST_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_stall_i,
    input  logic        if_flush_i,
    input  logic        take_branch_i,
    input  logic [31:0] pc_branch_address_i,
    input  logic        take_jump_i,
    input  logic [31:0] pc_jump_address_i,
    input  logic        trap_valid_i,
    input  logic [31:0] trap_address_i,
    output logic [31:0] iport_addr_o,
    output logic        iport_cyc_o,
    output logic        iport_stb_o,
    input  logic [31:0] iport_data_i,
    input  logic        iport_ack_i,
    input  logic        iport_err_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_instruction_o,
    output logic        id_inst_addr_misaligned_o,
    output logic        id_inst_access_fault_o,
    output logic        if_busy_o
);

    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    // Bus address is kept separately so it stays stable in KILL while pc holds the target.
    logic [31:0] addr_q, addr_d;
    logic        cyc_q, cyc_d;
    logic [31:0] hold_inst_q, hold_inst_d;
    logic        hold_err_q, hold_err_d;

    logic        redirect;
    logic [31:0] redirect_target;
    logic        bus_done;

    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_inst;
    logic        ifid_mis;
    logic        ifid_fault;

    // Trap wins; branch and jump are only honoured while decode is moving.
    always_comb begin
        redirect        = 1'b0;
        redirect_target = pc_q;
        if (trap_valid_i) begin
            redirect        = 1'b1;
            redirect_target = trap_address_i;
        end else if (!if_stall_i && take_branch_i) begin
            redirect        = 1'b1;
            redirect_target = pc_branch_address_i;
        end else if (!if_stall_i && take_jump_i) begin
            redirect        = 1'b1;
            redirect_target = pc_jump_address_i;
        end
    end

    // err alone or with ack both complete the request as an error.
    assign bus_done = cyc_q && (iport_ack_i || iport_err_i);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        addr_d      = addr_q;
        cyc_d       = cyc_q;
        hold_inst_d = hold_inst_q;
        hold_err_d  = hold_err_q;
        ifid_valid  = 1'b0;
        ifid_pc     = addr_q;
        ifid_inst   = NOP_INST;
        ifid_mis    = 1'b0;
        ifid_fault  = 1'b0;

        case (state_q)
            StFetch: begin
                if (redirect) begin
                    pc_d = redirect_target;
                    if (cyc_q && !bus_done) begin
                        state_d = StKill;
                    end else begin
                        addr_d = redirect_target;
                        cyc_d  = (redirect_target[1:0] == 2'b00);
                    end
                end else if (!cyc_q) begin
                    // Idle: either just out of reset or parked on a misaligned pc.
                    if (pc_q[1:0] != 2'b00) begin
                        ifid_valid = 1'b1;
                        ifid_pc    = pc_q;
                        ifid_mis   = 1'b1;
                    end else begin
                        addr_d = pc_q;
                        cyc_d  = 1'b1;
                    end
                end else if (bus_done) begin
                    if (if_stall_i) begin
                        hold_inst_d = iport_err_i ? NOP_INST : iport_data_i;
                        hold_err_d  = iport_err_i;
                        cyc_d       = 1'b0;
                        state_d     = StHold;
                    end else begin
                        ifid_valid = 1'b1;
                        ifid_inst  = iport_err_i ? NOP_INST : iport_data_i;
                        ifid_fault = iport_err_i;
                        pc_d       = pc_q + 32'd4;
                        addr_d     = pc_q + 32'd4;
                    end
                end
            end

            StKill: begin
                if (redirect) begin
                    pc_d = redirect_target;
                end
                if (bus_done) begin
                    state_d = StFetch;
                    addr_d  = pc_d;
                    cyc_d   = (pc_d[1:0] == 2'b00);
                end
            end

            StHold: begin
                if (redirect) begin
                    pc_d    = redirect_target;
                    addr_d  = redirect_target;
                    cyc_d   = (redirect_target[1:0] == 2'b00);
                    state_d = StFetch;
                end else if (!if_stall_i) begin
                    ifid_valid = 1'b1;
                    ifid_pc    = pc_q;
                    ifid_inst  = hold_inst_q;
                    ifid_fault = hold_err_q;
                    pc_d       = pc_q + 32'd4;
                    addr_d     = pc_q + 32'd4;
                    cyc_d      = 1'b1;
                    state_d    = StFetch;
                end
            end

            default: begin
                state_d = StFetch;
                cyc_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= StFetch;
            pc_q        <= RESET_ADDR;
            addr_q      <= RESET_ADDR;
            cyc_q       <= 1'b0;
            hold_inst_q <= NOP_INST;
            hold_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            addr_q      <= addr_d;
            cyc_q       <= cyc_d;
            hold_inst_q <= hold_inst_d;
            hold_err_q  <= hold_err_d;
        end
    end

    assign iport_addr_o = addr_q;
    assign iport_cyc_o  = cyc_q;
    assign iport_stb_o  = cyc_q;
    assign if_busy_o    = cyc_q && ((state_q == StFetch) || (state_q == StKill));

    titan_ifid_register #(
        .NOP_INST (NOP_INST)
    ) u_ifid (
        .clk_i                     (clk_i),
        .rst_i                     (rst_i),
        .flush_i                   (if_flush_i || redirect),
        .stall_i                   (if_stall_i),
        .valid_i                   (ifid_valid),
        .pc_i                      (ifid_pc),
        .inst_i                    (ifid_inst),
        .misaligned_i              (ifid_mis),
        .fault_i                   (ifid_fault),
        .id_pc_o                   (id_pc_o),
        .id_instruction_o          (id_instruction_o),
        .id_inst_addr_misaligned_o (id_inst_addr_misaligned_o),
        .id_inst_access_fault_o    (id_inst_access_fault_o)
    );

endmodule

// File: tb/tb_titan_if_stage.sv
module tb_titan_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        mis;
        logic        fault;
    } ifid_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        if_stall_i = 1'b0;
    logic        if_flush_i = 1'b0;
    logic        take_branch_i = 1'b0;
    logic [31:0] pc_branch_address_i = 32'h0;
    logic        take_jump_i = 1'b0;
    logic [31:0] pc_jump_address_i = 32'h0;
    logic        trap_valid_i = 1'b0;
    logic [31:0] trap_address_i = 32'h0;
    logic [31:0] iport_addr_o;
    logic        iport_cyc_o;
    logic        iport_stb_o;
    logic [31:0] iport_data_i;
    logic        iport_ack_i;
    logic        iport_err_i;
    logic [31:0] id_pc_o;
    logic [31:0] id_instruction_o;
    logic        id_inst_addr_misaligned_o;
    logic        id_inst_access_fault_o;
    logic        if_busy_o;

    // Memory responder controls and manual override used during reset.
    int          wait_states = 0;
    bit          auto_en = 1'b1;
    bit          err_en = 1'b0;
    logic [31:0] err_addr = 32'h0;
    logic        resp_ack = 1'b0;
    logic        resp_err = 1'b0;
    logic [31:0] resp_data = 32'h0;
    logic        man_ack = 1'b0;
    logic [31:0] man_data = 32'h0;

    assign iport_ack_i  = auto_en ? resp_ack : man_ack;
    assign iport_err_i  = auto_en ? resp_err : 1'b0;
    assign iport_data_i = auto_en ? resp_data : man_data;

    ifid_t exp_q[$];
    int    n_tests = 0;
    int    n_fail = 0;

    always #5 clk_i = ~clk_i;

    titan_if_stage dut (
        .clk_i                     (clk_i),
        .rst_i                     (rst_i),
        .if_stall_i                (if_stall_i),
        .if_flush_i                (if_flush_i),
        .take_branch_i             (take_branch_i),
        .pc_branch_address_i       (pc_branch_address_i),
        .take_jump_i               (take_jump_i),
        .pc_jump_address_i         (pc_jump_address_i),
        .trap_valid_i              (trap_valid_i),
        .trap_address_i            (trap_address_i),
        .iport_addr_o              (iport_addr_o),
        .iport_cyc_o               (iport_cyc_o),
        .iport_stb_o               (iport_stb_o),
        .iport_data_i              (iport_data_i),
        .iport_ack_i               (iport_ack_i),
        .iport_err_i               (iport_err_i),
        .id_pc_o                   (id_pc_o),
        .id_instruction_o          (id_instruction_o),
        .id_inst_addr_misaligned_o (id_inst_addr_misaligned_o),
        .id_inst_access_fault_o    (id_inst_access_fault_o),
        .if_busy_o                 (if_busy_o)
    );

    // Word at addr: imm = word index, rd = low index bits, addi opcode.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return {addr[13:2], 8'h00, addr[6:2], 7'h13};
    endfunction

    // Bus slave: answers after wait_states idle cycles, err on err_addr.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk_i);
            #1;
            if (auto_en && rst_i && iport_cyc_o && iport_stb_o) begin
                if (cnt >= wait_states) begin
                    cnt = 0;
                    if (err_en && iport_addr_o == err_addr) begin
                        resp_ack  = 1'b0;
                        resp_err  = 1'b1;
                        resp_data = 32'hDEAD_BEEF;
                    end else begin
                        resp_ack  = 1'b1;
                        resp_err  = 1'b0;
                        resp_data = mem_word(iport_addr_o);
                    end
                end else begin
                    cnt++;
                    resp_ack = 1'b0;
                    resp_err = 1'b0;
                end
            end else begin
                cnt      = 0;
                resp_ack = 1'b0;
                resp_err = 1'b0;
            end
        end
    end

    // Monitor: each new non-bubble IF/ID entry is compared with the scoreboard head.
    initial begin
        ifid_t cur;
        ifid_t prev;
        ifid_t e;
        prev = '0;
        forever begin
            @(negedge clk_i);
            cur = {id_pc_o, id_instruction_o, id_inst_addr_misaligned_o, id_inst_access_fault_o};
            if (cur.pc != 32'h0 && cur != prev) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL ifid_extra: got pc=%h inst=%h mis=%b fault=%b, expected none",
                             cur.pc, cur.inst, cur.mis, cur.fault);
                end else begin
                    e = exp_q.pop_front();
                    if (cur != e) begin
                        n_fail++;
                        $display("FAIL ifid: got pc=%h inst=%h mis=%b fault=%b, expected pc=%h inst=%h mis=%b fault=%b",
                                 cur.pc, cur.inst, cur.mis, cur.fault, e.pc, e.inst, e.mis, e.fault);
                    end
                end
            end
            prev = cur;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_ifid(input logic [31:0] pc, input logic [31:0] inst,
                               input logic mis, input logic fault);
        ifid_t e;
        e = {pc, inst, mis, fault};
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    // Holds reset across an edge, checks reset values, then releases mid-cycle.
    task automatic do_reset(input int ws, input bit errs, input logic [31:0] eaddr);
        rst_i         = 1'b0;
        if_stall_i    = 1'b0;
        if_flush_i    = 1'b0;
        take_branch_i = 1'b0;
        take_jump_i   = 1'b0;
        trap_valid_i  = 1'b0;
        wait_states   = ws;
        err_en        = errs;
        err_addr      = eaddr;
        @(negedge clk_i);
        #1;
        check("rst_cyc", {31'h0, iport_cyc_o}, 32'h0);
        check("rst_stb", {31'h0, iport_stb_o}, 32'h0);
        check("rst_busy", {31'h0, if_busy_o}, 32'h0);
        check("rst_id_pc", id_pc_o, 32'h0);
        check("rst_id_inst", id_instruction_o, NOP);
        check("rst_id_flags", {30'h0, id_inst_addr_misaligned_o, id_inst_access_fault_o}, 32'h0);
        rst_i = 1'b1;
    endtask

    task automatic end_test(input string name);
        @(negedge clk_i);
        #1;
        rst_i = 1'b0;
        check(name, 32'(exp_q.size()), 32'h0);
        exp_q.delete();
    endtask

    initial begin
        #2;
        rst_i = 1'b0;

        // 1: zero-wait streaming from reset.
        expect_ifid(32'h8000_0000, 32'h0000_0013, 1'b0, 1'b0);
        expect_ifid(32'h8000_0004, 32'h0010_0093, 1'b0, 1'b0);
        expect_ifid(32'h8000_0008, 32'h0020_0113, 1'b0, 1'b0);
        expect_ifid(32'h8000_000C, 32'h0030_0193, 1'b0, 1'b0);
        expect_ifid(32'h8000_0010, 32'h0040_0213, 1'b0, 1'b0);
        expect_ifid(32'h8000_0014, 32'h0050_0293, 1'b0, 1'b0);
        do_reset(0, 1'b0, 32'h0);
        step(1);
        check("t1_first_addr", iport_addr_o, 32'h8000_0000);
        check("t1_first_cyc", {30'h0, iport_cyc_o, iport_stb_o}, 32'h3);
        check("t1_busy", {31'h0, if_busy_o}, 32'h1);
        check("t1_ifid_not_yet", id_pc_o, 32'h0);
        for (int i = 1; i < 6; i++) begin
            step(1);
            check("t1_addr_seq", iport_addr_o, 32'h8000_0000 + 32'(4 * i));
        end
        step(1);
        end_test("t1_drain");

        // 2: branch while a 2-wait fetch is outstanding.
        expect_ifid(32'h8000_0000, 32'h0000_0013, 1'b0, 1'b0);
        expect_ifid(32'h8000_0004, 32'h0010_0093, 1'b0, 1'b0);
        expect_ifid(32'h8000_0100, 32'h0400_0013, 1'b0, 1'b0);
        do_reset(2, 1'b0, 32'h0);
        step(7);
        check("t2_pending_addr", iport_addr_o, 32'h8000_0008);
        take_branch_i       = 1'b1;
        pc_branch_address_i = 32'h8000_0100;
        step(1);
        take_branch_i = 1'b0;
        check("t2_kill_addr_stable", iport_addr_o, 32'h8000_0008);
        check("t2_kill_busy", {31'h0, if_busy_o}, 32'h1);
        check("t2_kill_bubble", id_instruction_o, NOP);
        step(2);
        check("t2_target_addr", iport_addr_o, 32'h8000_0100);
        check("t2_target_cyc", {31'h0, iport_cyc_o}, 32'h1);
        step(3);
        end_test("t2_drain");

        // 3: stall across the ack parks the word and idles the bus.
        expect_ifid(32'h8000_0000, 32'h0000_0013, 1'b0, 1'b0);
        expect_ifid(32'h8000_0004, 32'h0010_0093, 1'b0, 1'b0);
        expect_ifid(32'h8000_0008, 32'h0020_0113, 1'b0, 1'b0);
        do_reset(0, 1'b0, 32'h0);
        step(2);
        if_stall_i = 1'b1;
        step(1);
        check("t3_hold_cyc", {31'h0, iport_cyc_o}, 32'h0);
        check("t3_hold_busy", {31'h0, if_busy_o}, 32'h0);
        step(2);
        check("t3_hold_ifid", id_pc_o, 32'h8000_0000);
        check("t3_hold_cyc_late", {31'h0, iport_cyc_o}, 32'h0);
        if_stall_i = 1'b0;
        step(1);
        check("t3_release_addr", iport_addr_o, 32'h8000_0008);
        check("t3_release_ifid", id_pc_o, 32'h8000_0004);
        step(1);
        end_test("t3_drain");

        // 4: bus error then trap redirect.
        expect_ifid(32'h8000_0000, 32'h0000_0013, 1'b0, 1'b0);
        expect_ifid(32'h8000_0004, 32'h0010_0093, 1'b0, 1'b0);
        expect_ifid(32'h8000_0008, 32'h0020_0113, 1'b0, 1'b0);
        expect_ifid(32'h8000_000C, 32'h0030_0193, 1'b0, 1'b0);
        expect_ifid(32'h8000_0010, NOP, 1'b0, 1'b1);
        expect_ifid(32'h0000_0200, 32'h0800_0013, 1'b0, 1'b0);
        expect_ifid(32'h0000_0204, 32'h0810_0093, 1'b0, 1'b0);
        do_reset(0, 1'b1, 32'h8000_0010);
        step(6);
        check("t4_fault_flag", {31'h0, id_inst_access_fault_o}, 32'h1);
        trap_valid_i   = 1'b1;
        trap_address_i = 32'h0000_0200;
        step(1);
        trap_valid_i = 1'b0;
        check("t4_trap_addr", iport_addr_o, 32'h0000_0200);
        check("t4_trap_bubble", id_instruction_o, NOP);
        step(2);
        end_test("t4_drain");

        // 5: jump to a misaligned target parks the pc until a trap.
        expect_ifid(32'h8000_0022, NOP, 1'b1, 1'b0);
        expect_ifid(32'h8000_0040, 32'h0100_0813, 1'b0, 1'b0);
        do_reset(0, 1'b0, 32'h0);
        step(1);
        take_jump_i       = 1'b1;
        pc_jump_address_i = 32'h8000_0022;
        step(1);
        take_jump_i = 1'b0;
        check("t5_no_request", {31'h0, iport_cyc_o}, 32'h0);
        check("t5_not_busy", {31'h0, if_busy_o}, 32'h0);
        step(3);
        check("t5_still_idle", {31'h0, iport_cyc_o}, 32'h0);
        check("t5_mis_pc", id_pc_o, 32'h8000_0022);
        trap_valid_i   = 1'b1;
        trap_address_i = 32'h8000_0040;
        step(1);
        trap_valid_i = 1'b0;
        check("t5_trap_addr", iport_addr_o, 32'h8000_0040);
        check("t5_trap_cyc", {31'h0, iport_cyc_o}, 32'h1);
        step(1);
        end_test("t5_drain");

        // 6: reset asserted mid-fetch, ack during reset ignored.
        do_reset(2, 1'b0, 32'h0);
        step(1);
        check("t6_req_addr", iport_addr_o, 32'h8000_0000);
        #2;
        rst_i = 1'b0;
        #1;
        check("t6_async_cyc", {30'h0, iport_cyc_o, iport_stb_o}, 32'h0);
        check("t6_async_busy", {31'h0, if_busy_o}, 32'h0);
        auto_en  = 1'b0;
        man_ack  = 1'b1;
        man_data = 32'h0BAD_C0DE;
        step(2);
        check("t6_ack_in_reset_cyc", {31'h0, iport_cyc_o}, 32'h0);
        check("t6_ack_in_reset_ifid", id_instruction_o, NOP);
        man_ack = 1'b0;
        auto_en = 1'b1;
        expect_ifid(32'h8000_0000, 32'h0000_0013, 1'b0, 1'b0);
        do_reset(0, 1'b0, 32'h0);
        step(1);
        check("t6_refetch_addr", iport_addr_o, 32'h8000_0000);
        step(1);
        end_test("t6_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
